// File: rtl/round_update_scheduler.sv
// Round-based update sequencer: picks each element exactly once per round from a
// random index stream, counts rounds and stops on steady state, round limit or abort.
module round_update_scheduler #(
    parameter int N_ELEM        = 16,
    parameter int LOG_N         = 4,
    parameter int LOG_ROUNDS    = 8,
    parameter int MAX_ROUNDS    = 200,
    parameter int STABLE_ROUNDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOG_N-1:0]      rnd,
    input  logic                  upd_ready,
    input  logic                  upd_changed,
    output logic                  upd_valid,
    output logic [LOG_N-1:0]      upd_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  steady,
    output logic [LOG_ROUNDS-1:0] round_count
);
    localparam int SW = $clog2(STABLE_ROUNDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nx;
    logic [N_ELEM-1:0]     pending, pending_clr;
    logic [SW-1:0]         stable_cnt, stable_nx;
    logic [LOG_ROUNDS-1:0] round_nx;
    logic                  chg_flag, commit, round_end, hit_steady, hit_limit;
    logic [LOG_N-1:0]      sel, sel_hi, sel_lo;
    logic                  found_hi;
    int                    start_pos;

    // Circular search = lowest pending index at/above the start point, else lowest overall.
    always_comb begin
        start_pos = (int'(rnd) < N_ELEM) ? int'(rnd) : 0;
        sel_hi    = '0;
        sel_lo    = '0;
        found_hi  = 1'b0;
        for (int i = N_ELEM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_lo = LOG_N'(i);
                if (i >= start_pos) begin
                    sel_hi   = LOG_N'(i);
                    found_hi = 1'b1;
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign upd_valid   = busy && !abort;
    assign upd_idx     = busy ? sel : '0;
    assign commit      = upd_valid && upd_ready;
    assign pending_clr = pending & ~(N_ELEM'(1) << sel);
    assign round_end   = commit && (pending_clr == '0);
    assign round_nx    = round_count + LOG_ROUNDS'(1);
    assign stable_nx   = (chg_flag || upd_changed) ? '0 : stable_cnt + SW'(1);
    assign hit_steady  = (stable_nx == SW'(STABLE_ROUNDS));
    assign hit_limit   = (round_nx == LOG_ROUNDS'(MAX_ROUNDS));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN: begin
                if (abort)
                    state_nx = S_IDLE;
                else if (round_end && (hit_steady || hit_limit))
                    state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            pending     <= '0;
            round_count <= '0;
            stable_cnt  <= '0;
            chg_flag    <= 1'b0;
            steady      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                pending     <= '1;
                round_count <= '0;
                stable_cnt  <= '0;
                chg_flag    <= 1'b0;
                steady      <= 1'b0;
            end else if (busy && abort) begin
                steady <= 1'b0;
            end else if (commit) begin
                if (round_end) begin
                    pending     <= '1;
                    round_count <= round_nx;
                    stable_cnt  <= stable_nx;
                    chg_flag    <= 1'b0;
                    steady      <= hit_steady;
                end else begin
                    pending  <= pending_clr;
                    chg_flag <= chg_flag || upd_changed;
                end
            end
        end
    end
endmodule

// File: tb/tb_round_update_scheduler.sv
// Scoreboard bench for round_update_scheduler: a set-based reference model predicts
// every cycle's outputs; a monitor pops and compares them independently of stimulus.
module tb_round_update_scheduler;
    localparam int N = 4, LN = 3, LR = 8, MAXR = 8, STAB = 2;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic          upd_ready = 1'b0, upd_changed = 1'b0;
    logic [LN-1:0] rnd = '0;
    logic          upd_valid, busy, done, steady;
    logic [LN-1:0] upd_idx;
    logic [LR-1:0] round_count;

    always #5 clk = ~clk;

    round_update_scheduler #(
        .N_ELEM(N), .LOG_N(LN), .LOG_ROUNDS(LR), .MAX_ROUNDS(MAXR), .STABLE_ROUNDS(STAB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rnd(rnd),
        .upd_ready(upd_ready), .upd_changed(upd_changed), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .busy(busy), .done(done), .steady(steady),
        .round_count(round_count)
    );

    typedef struct {
        bit valid; int idx; bit busy; bit done; bit steady; int rc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;

    // Reference model: 0 idle, 1 running, 2 done; pending set as a bit array.
    int m_mode = 0, m_rounds = 0, m_stable = 0;
    bit m_pend[N];
    bit m_chg = 0, m_steady = 0, m_known = 0;

    function automatic int pick(input int r);
        int s = (r < N) ? r : 0;
        for (int k = 0; k < N; k++)
            if (m_pend[(s + k) % N]) return (s + k) % N;
        return 0;
    endfunction

    function automatic bit all_clear();
        foreach (m_pend[i]) if (m_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc(input bit rs, input bit st, input bit ab, input int r,
                       input bit rdy, input bit chg);
        exp_t e;
        @(negedge clk);
        rst = rs; start = st; abort = ab; rnd = LN'(r);
        upd_ready = rdy; upd_changed = chg;
        e.busy   = (m_mode == 1);
        e.done   = (m_mode == 2);
        e.valid  = (m_mode == 1) && !ab;
        e.idx    = e.valid ? pick(r) : 0;
        e.steady = m_steady;
        e.rc     = m_rounds;
        if (m_known) sb.push_back(e);
        if (!rs) begin
            m_mode = 0; m_rounds = 0; m_stable = 0; m_chg = 0; m_steady = 0; m_known = 1;
            foreach (m_pend[i]) m_pend[i] = 0;
        end else begin
            case (m_mode)
                0: if (st) begin
                    m_mode = 1; m_rounds = 0; m_stable = 0; m_chg = 0; m_steady = 0;
                    foreach (m_pend[i]) m_pend[i] = 1;
                end
                1: if (ab) begin
                    m_mode = 0; m_steady = 0;
                end else if (rdy) begin
                    m_pend[e.idx] = 0;
                    m_chg |= chg;
                    if (all_clear()) begin
                        foreach (m_pend[i]) m_pend[i] = 1;
                        m_rounds++;
                        m_stable = m_chg ? 0 : m_stable + 1;
                        m_chg = 0;
                        if (m_stable == STAB) begin
                            m_mode = 2; m_steady = 1;
                        end else if (m_rounds == MAXR) begin
                            m_mode = 2;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic dchk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // rmode: fixed rnd or -1 random; ymode: 0 ready, 1 toggle, 2 random; cmode: 0 none, 1 all, 2 round 2 only
    task automatic run(input string nm, input int rmode, input int ymode, input int cmode,
                       input int w_steady, input int w_rc);
        bit tog = 1'b1;
        bit rdy, chg;
        int n = 0, r;
        cyc(1, 1, 0, 0, 0, 0);
        while (m_mode != 2 && n < 400) begin
            r   = (rmode < 0) ? int'($urandom_range(0, 7)) : rmode;
            rdy = (ymode == 0) ? 1'b1 : (ymode == 1) ? tog : ($urandom % 4 != 0);
            tog = ~tog;
            chg = (cmode == 1) ? 1'b1 : (cmode == 2) ? (m_rounds == 1) : 1'b0;
            cyc(1, 0, 0, r, rdy, chg);
            n++;
        end
        if (m_mode != 2) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no termination after %0d cycles, expected one", nm, n);
        end
        cyc(1, 0, 0, 0, 0, 0);
        #3;
        dchk({nm, "_done"}, int'(done), 1);
        dchk({nm, "_steady"}, int'(steady), w_steady);
        dchk({nm, "_rc"}, int'(round_count), w_rc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (upd_valid !== e.valid || busy !== e.busy || done !== e.done ||
                    steady !== e.steady || round_count !== LR'(e.rc) ||
                    (e.valid && upd_idx !== LN'(e.idx))) begin
                    failures++;
                    $display("FAIL cycle t=%0t: got v=%b idx=%0d busy=%b done=%b steady=%b rc=%0d, expected v=%b idx=%0d busy=%b done=%b steady=%b rc=%0d",
                             $time, upd_valid, upd_idx, busy, done, steady, round_count,
                             e.valid, e.idx, e.busy, e.done, e.steady, e.rc);
                end
            end
        end
    end

    initial begin : driver
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 1, 0);
        #3;
        dchk("idle_busy", int'(busy), 0);
        dchk("idle_valid", int'(upd_valid), 0);

        run("seq0", 0, 0, 0, 1, 2);
        run("seq2", 2, 0, 0, 1, 2);
        run("seq7", 7, 0, 0, 1, 2);
        run("allchg", -1, 0, 1, 0, 8);
        run("chg_r2", 0, 0, 2, 1, 4);
        run("toggle", -1, 1, 0, 1, 2);

        // Abort after 5 commits: one round complete, then abort wins over a commit.
        cyc(1, 1, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, int'($urandom_range(0, 7)), 1, 0);
        cyc(1, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        #3;
        dchk("abort_busy", int'(busy), 0);
        dchk("abort_done", int'(done), 0);
        dchk("abort_steady", int'(steady), 0);
        dchk("abort_rc", int'(round_count), 1);
        run("after_abort", -1, 2, 0, 1, 2);

        // Random traffic with stray starts, rare aborts and an occasional mid-run reset.
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 150; c++)
                cyc(($urandom % 120) != 0, ($urandom % 4) == 0, ($urandom % 60) == 0,
                    int'($urandom_range(0, 7)), ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        #4;
        dchk("drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
